// File: rtl/rv_lsu_ctrl.sv
// rv_lsu_ctrl: load/store unit bus controller with IDLE/REQ/WAIT/DONE handshake FSM.
// Optional bus timeout abort enabled by defining RV_LSU_TIMEOUT_EN.
module rv_lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [2:0]  funct3_i,
    input  logic [63:0] addr_map_i,
    input  logic [7:0]  wr_strobe_i,
    input  logic [63:0] wr_data_i,
    output logic        stall_o,
    output logic [63:0] rd_data_o,
    output logic        rd_valid_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [63:0] bus_addr_o,
    output logic [7:0]  bus_strb_o,
    output logic [63:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [63:0] bus_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [7:0]  strb_q, strb_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        err_q, err_d;
    logic [63:0] wdata_rep;
    logic        tmo;
    logic        unused_f3;

    assign unused_f3 = funct3_i[2];

    assign wdata_rep = funct3_i[1:0] == 2'b00 ? {8{wr_data_i[7:0]}}  :
                       funct3_i[1:0] == 2'b01 ? {4{wr_data_i[15:0]}} :
                       funct3_i[1:0] == 2'b10 ? {2{wr_data_i[31:0]}} : wr_data_i;

`ifdef RV_LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter is zero on the first REQ cycle, so the Nth REQ/WAIT cycle sees N-1.
    assign cnt_d = (state_q == REQ || state_q == WAIT) ? cnt_q + CW'(1) : '0;
    assign tmo   = (state_q == REQ || state_q == WAIT) && cnt_q == CW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        strb_d     = strb_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: if (mem_req_i) begin
                we_d    = mem_we_i;
                addr_d  = addr_map_i;
                strb_d  = wr_strobe_i;
                wdata_d = wdata_rep;
                state_d = REQ;
            end
            REQ: if (bus_gnt_i) begin
                state_d = we_q ? DONE : WAIT;
            end else if (tmo) begin
                state_d   = DONE;
                err_d     = 1'b1;
                rd_data_d = we_q ? rd_data_q : '0;
            end
            // A real rvalid on the timeout cycle still completes the load.
            WAIT: if (bus_rvalid_i) begin
                rd_data_d  = bus_rdata_i;
                rd_valid_d = 1'b1;
                state_d    = DONE;
            end else if (tmo) begin
                state_d   = DONE;
                err_d     = 1'b1;
                rd_data_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            strb_q     <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            strb_q     <= strb_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // Reset gates stall so a held request cannot stall the pipe during reset.
    assign stall_o     = !rst_i && ((state_q == IDLE && mem_req_i) || state_q == REQ || state_q == WAIT);
    assign bus_req_o   = state_q == REQ;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_strb_o  = strb_q;
    assign bus_wdata_o = wdata_q;
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_rv_lsu_ctrl.sv
// tb_rv_lsu_ctrl: randomized transaction-level self-checking bench for rv_lsu_ctrl.
module tb_rv_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        mem_req_i = 1'b0, mem_we_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [63:0] addr_map_i = '0, wr_data_i = '0, bus_rdata_i = '0;
    logic [7:0]  wr_strobe_i = '0;
    logic        bus_gnt_i = 1'b0, bus_rvalid_i = 1'b0;
    logic        stall_o, rd_valid_o, err_o, bus_req_o, bus_we_o;
    logic [63:0] rd_data_o, bus_addr_o, bus_wdata_o;
    logic [7:0]  bus_strb_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] model_rd = '0;

    always #5 clk = ~clk;

    rv_lsu_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst_i), .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
        .funct3_i(funct3_i), .addr_map_i(addr_map_i), .wr_strobe_i(wr_strobe_i),
        .wr_data_i(wr_data_i), .stall_o(stall_o), .rd_data_o(rd_data_o),
        .rd_valid_o(rd_valid_o), .err_o(err_o), .bus_req_o(bus_req_o),
        .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_strb_o(bus_strb_o),
        .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Lane replication by arithmetic: a pattern times a "ones in each lane" constant.
    function automatic logic [63:0] exp_wdata(input logic [2:0] f3, input logic [63:0] d);
        case (f3[1:0])
            2'b00:   return {56'd0, d[7:0]}  * 64'h0101010101010101;
            2'b01:   return {48'd0, d[15:0]} * 64'h0001000100010001;
            2'b10:   return {32'd0, d[31:0]} * 64'h0000000100000001;
            default: return d;
        endcase
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic idle_cycle();
        @(negedge clk);
        mem_req_i    = 1'b0;
        bus_gnt_i    = 1'($urandom);
        bus_rvalid_i = 1'($urandom);
        bus_rdata_i  = rnd64();
        #1;
        check("idle_stall", 64'(stall_o), 64'd0);
        check("idle_busreq", 64'(bus_req_o), 64'd0);
        check("idle_rdvalid", 64'(rd_valid_o), 64'd0);
        check("idle_rddata", rd_data_o, model_rd);
    endtask

    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [63:0] a,
                          input logic [7:0] s, input logic [63:0] d, input int gdly,
                          input int rdly, input logic [63:0] rdat);
        logic [63:0] ew;
        ew = exp_wdata(f3, d);
        @(negedge clk);
        mem_req_i = 1'b1; mem_we_i = we; funct3_i = f3;
        addr_map_i = a; wr_strobe_i = s; wr_data_i = d;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'($urandom); bus_rdata_i = rnd64();
        #1;
        check("req_stall", 64'(stall_o), 64'd1);
        check("req_busreq_idle", 64'(bus_req_o), 64'd0);
        for (int i = 0; i <= gdly; i++) begin
            @(negedge clk);
            bus_gnt_i = (i == gdly);
            bus_rvalid_i = 1'($urandom);
            wr_data_i = rnd64(); addr_map_i = rnd64(); wr_strobe_i = 8'($urandom);
            #1;
            check("busreq", 64'(bus_req_o), 64'd1);
            check("stall_req", 64'(stall_o), 64'd1);
            check("bus_we", 64'(bus_we_o), 64'(we));
            check("bus_addr", bus_addr_o, a);
            check("bus_strb", 64'(bus_strb_o), 64'(s));
            check("bus_wdata", bus_wdata_o, ew);
            check("rdvalid_req", 64'(rd_valid_o), 64'd0);
        end
        if (!we) begin
            for (int j = 0; j <= rdly; j++) begin
                @(negedge clk);
                bus_gnt_i = 1'($urandom);
                bus_rvalid_i = (j == rdly);
                bus_rdata_i = (j == rdly) ? rdat : rnd64();
                #1;
                check("wait_busreq", 64'(bus_req_o), 64'd0);
                check("wait_stall", 64'(stall_o), 64'd1);
                check("wait_rddata", rd_data_o, model_rd);
            end
        end
        @(negedge clk);
        bus_gnt_i = 1'($urandom); bus_rvalid_i = 1'($urandom); bus_rdata_i = rnd64();
        if (!we) model_rd = rdat;
        #1;
        check("done_stall", 64'(stall_o), 64'd0);
        check("done_busreq", 64'(bus_req_o), 64'd0);
        check("done_rdvalid", 64'(rd_valid_o), 64'(!we));
        check("done_err", 64'(err_o), 64'd0);
        check("done_rddata", rd_data_o, model_rd);
    endtask

    initial begin
        mem_req_i = 1'b1;
        #3;
        check("rst_stall", 64'(stall_o), 64'd0);
        check("rst_busreq", 64'(bus_req_o), 64'd0);
        check("rst_rddata", rd_data_o, 64'd0);
        check("rst_rdvalid", 64'(rd_valid_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_wdata", bus_wdata_o, 64'd0);
        @(negedge clk);
        rst_i = 1'b0;
        mem_req_i = 1'b0;
        idle_cycle();
        // Load D, immediate gnt and rvalid.
        do_txn(1'b0, 3'b011, 64'h10, 8'hFF, rnd64(), 0, 0, 64'h1122334455667788);
        idle_cycle();
        // Store B with gnt delayed three cycles.
        do_txn(1'b1, 3'b000, 64'h40, 8'h04, 64'hAB, 3, 0, 64'd0);
        idle_cycle();
        // Back-to-back load then store with no gap.
        do_txn(1'b0, 3'b010, 64'h88, 8'h0F, rnd64(), 1, 1, rnd64());
        do_txn(1'b1, 3'b001, 64'h90, 8'h30, rnd64(), 0, 0, 64'd0);
        // Reset mid-WAIT.
        @(negedge clk);
        mem_req_i = 1'b1; mem_we_i = 1'b0; funct3_i = 3'b011; addr_map_i = 64'h100;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        @(negedge clk);
        bus_gnt_i = 1'b1;
        @(negedge clk);
        bus_gnt_i = 1'b0;
        #1;
        check("rstw_stall_before", 64'(stall_o), 64'd1);
        rst_i = 1'b1;
        model_rd = '0;
        #1;
        check("rstw_stall", 64'(stall_o), 64'd0);
        check("rstw_busreq", 64'(bus_req_o), 64'd0);
        check("rstw_rddata", rd_data_o, model_rd);
        @(negedge clk);
        rst_i = 1'b0;
        mem_req_i = 1'b0;
        bus_rvalid_i = 1'b1; bus_rdata_i = rnd64();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("rstw_rdvalid", 64'(rd_valid_o), 64'd0);
            check("rstw_rddata_hold", rd_data_o, model_rd);
        end
`ifdef RV_LSU_TIMEOUT_EN
        @(negedge clk);
        mem_req_i = 1'b1; mem_we_i = 1'b0; funct3_i = 3'b011;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            check("tmo_busreq", 64'(bus_req_o), 64'd1);
            check("tmo_err_early", 64'(err_o), 64'd0);
        end
        @(negedge clk);
        model_rd = '0;
        #1;
        check("tmo_err", 64'(err_o), 64'd1);
        check("tmo_rdvalid", 64'(rd_valid_o), 64'd0);
        check("tmo_rddata", rd_data_o, model_rd);
        check("tmo_stall", 64'(stall_o), 64'd0);
        idle_cycle();
        check("tmo_err_clear", 64'(err_o), 64'd0);
`endif
        for (int t = 0; t < 60; t++) begin
            logic we;
            we = 1'($urandom);
            do_txn(we, 3'($urandom), rnd64() & ~64'h7, 8'($urandom), rnd64(),
                   $urandom_range(0, 3), $urandom_range(0, 2), rnd64());
            for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
